// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, state type and switch-to-ratio encoding for the divider
package clk_div_pkg;
  localparam int MIN_DIV = 2;
  typedef enum logic {STOPPED, RUNNING} state_t;
  function automatic logic [31:0] sel_to_div(input logic [31:0] sel, input int sel_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < sel_w && sel[i]) r = 32'(1) << (sel_w - i);
    return r;
  endfunction
endpackage

// File: rtl/clk_div_prog_div_resolve.sv
// div_resolve: resolves switches / runtime divisor into the requested ratio (0 = stop)
module div_resolve
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 14,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             div_en,
  input  logic [CNT_W-1:0] div_val,
  output logic [CNT_W-1:0] d_req
);
  // runtime divisor wins over switches; divisors below the minimum are clamped up
  always_comb
    d_req = div_en ? ((div_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_val)
                   : CNT_W'(sel_to_div(32'(sel), SEL_W));
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50%-duty clock divider with boundary-synchronised ratio changes
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W = 14,
  parameter int SEL_W = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             div_en,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] active_div
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, div_d, d_req;
  logic [CNT_W:0]   half;
  logic             clk_d, tick_d, restart, go;

  div_resolve #(.CNT_W(CNT_W), .SEL_W(SEL_W)) u_resolve (
    .sel(sel), .div_en(div_en), .div_val(div_val), .d_req(d_req)
  );

  // a new period starts from STOPPED or at the last count; only then is the request sampled
  always_comb begin
    half    = ({1'b0, active_div} + (CNT_W+1)'(1)) >> 1;
    restart = (state_q == STOPPED) || (cnt == active_div - CNT_W'(1));
    go      = d_req != '0;
    state_d = restart ? (go ? RUNNING : STOPPED) : state_q;
    cnt_d   = restart ? '0 : cnt + CNT_W'(1);
    div_d   = restart ? d_req : active_div;
    clk_d   = restart ? go : (({1'b0, cnt} + (CNT_W+1)'(1)) < half);
    tick_d  = restart && go;
  end

  // state, counter and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= STOPPED;
      cnt        <= '0;
      active_div <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt        <= cnt_d;
      active_div <= div_d;
      clk_out    <= clk_d;
      tick       <= tick_d;
    end
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: randomized and directed checks of clk_div_prog against a period/phase model
module tb_clk_div_prog;
  localparam int CNT_W = 14;
  localparam int SEL_W = 4;

  logic             clk_in = 0;
  logic             rst = 1;
  logic [SEL_W-1:0] sel = '0;
  logic             div_en = 0;
  logic [CNT_W-1:0] div_val = '0;
  logic             clk_out, tick;
  logic [CNT_W-1:0] active_div;

  int vecs = 0, errs = 0;
  int m_d = 0, m_p = 0;
  logic m_clk, m_tick;
  logic [CNT_W-1:0] m_div;

  clk_div_prog #(.CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk_in(clk_in), .rst(rst), .sel(sel), .div_en(div_en), .div_val(div_val),
    .clk_out(clk_out), .tick(tick), .active_div(active_div)
  );

  always #5 clk_in = ~clk_in;

  function automatic int req_ratio();
    if (div_en) return (int'(div_val) < 2) ? 2 : int'(div_val);
    for (int k = SEL_W - 1; k >= 0; k--) if (sel[k]) return 1 << (SEL_W - k);
    return 0;
  endfunction

  // advance one clock; the model holds a ratio D and a phase p within the current period
  task automatic cyc();
    int r;
    r = req_ratio();
    @(posedge clk_in);
    if (rst) begin m_d = 0; m_p = 0; end
    else if (m_d == 0 || m_p == m_d - 1) begin m_d = r; m_p = 0; end
    else m_p++;
    m_div  = CNT_W'(m_d);
    m_clk  = (m_d != 0) && (m_p < (m_d + 1) / 2);
    m_tick = (m_d != 0) && (m_p == 0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; sel = 4'b1000;
    repeat (3) begin
      cyc();
      vecs++;
      if ({clk_out, tick, active_div} !== {1'b0, 1'b0, CNT_W'(0)}) begin
        errs++;
        $display("FAIL reset: got clk=%b tick=%b div=%0d, want 0 0 0", clk_out, tick, active_div);
      end
    end
  endtask

  task automatic test_div2();
    rst = 0; sel = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      cyc();
      vecs++;
      if ({clk_out, tick, active_div} !== {m_clk, m_tick, m_div} || active_div !== CNT_W'(2)) begin
        errs++;
        $display("FAIL div2 c%0d: got clk=%b tick=%b div=%0d, want %b %b %0d", i, clk_out, tick, active_div, m_clk, m_tick, m_div);
      end
    end
  endtask

  task automatic test_switch_mid_period();
    int highs;
    sel = 4'b0001;
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 24) sel = 4'b0100;
      cyc();
      if (i >= 2 && i < 18) highs += int'(clk_out);
      vecs++;
      if ({clk_out, tick, active_div} !== {m_clk, m_tick, m_div}) begin
        errs++;
        $display("FAIL switch c%0d: got clk=%b tick=%b div=%0d, want %b %b %0d", i, clk_out, tick, active_div, m_clk, m_tick, m_div);
      end
    end
    vecs++;
    if (highs != 8) begin
      errs++;
      $display("FAIL duty16: got %0d high cycles in a period, want 8", highs);
    end
  endtask

  task automatic test_div_val();
    div_en = 1; div_val = 5; sel = 4'b1000;
    for (int i = 0; i < 50; i++) begin
      if (i == 25) div_val = 1;
      if (i == 40) div_val = 0;
      cyc();
      vecs++;
      if ({clk_out, tick, active_div} !== {m_clk, m_tick, m_div}) begin
        errs++;
        $display("FAIL divval c%0d: got clk=%b tick=%b div=%0d, want %b %b %0d", i, clk_out, tick, active_div, m_clk, m_tick, m_div);
      end
    end
  endtask

  task automatic test_priority_stop();
    div_en = 0; sel = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) sel = '0;
      cyc();
      vecs++;
      if ({clk_out, tick, active_div} !== {m_clk, m_tick, m_div}) begin
        errs++;
        $display("FAIL prio c%0d: got clk=%b tick=%b div=%0d, want %b %b %0d", i, clk_out, tick, active_div, m_clk, m_tick, m_div);
      end
    end
    vecs++;
    if ({clk_out, tick, active_div} !== {1'b0, 1'b0, CNT_W'(0)}) begin
      errs++;
      $display("FAIL stopped: got clk=%b tick=%b div=%0d, want 0 0 0", clk_out, tick, active_div);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    sel = 4'b0010;
    n = 0;
    do begin cyc(); n++; end while (!(m_d == 8 && m_p == 3) && n < 30);
    vecs++;
    if (n >= 30 || active_div !== CNT_W'(8)) begin
      errs++;
      $display("FAIL midrst_setup: got div=%0d after %0d cycles, want 8 at phase 3", active_div, n);
    end
    rst = 1;
    cyc();
    vecs++;
    if ({clk_out, tick, active_div} !== {1'b0, 1'b0, CNT_W'(0)}) begin
      errs++;
      $display("FAIL midrst: got clk=%b tick=%b div=%0d, want 0 0 0", clk_out, tick, active_div);
    end
    rst = 0;
    cyc();
    vecs++;
    if ({clk_out, tick, active_div} !== {1'b1, 1'b1, CNT_W'(8)}) begin
      errs++;
      $display("FAIL restart: got clk=%b tick=%b div=%0d, want 1 1 8", clk_out, tick, active_div);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        sel     = SEL_W'($urandom);
        div_en  = 1'($urandom);
        div_val = CNT_W'($urandom_range(0, 12));
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc();
      vecs++;
      if ({clk_out, tick, active_div} !== {m_clk, m_tick, m_div}) begin
        errs++;
        $display("FAIL random c%0d: got clk=%b tick=%b div=%0d, want %b %b %0d", i, clk_out, tick, active_div, m_clk, m_tick, m_div);
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_div2();
    test_switch_mid_period();
    test_div_val();
    test_priority_stop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
